// File: rtl/huc6280_timer_irq.sv
// huc6280_timer_irq: CPU-bus timer and interrupt controller; drives the level IRQ from the timer and two external lines
module huc6280_timer_irq #(
    parameter logic [15:0] TIMER_BASE = 16'h0C00,
    parameter logic [15:0] IRQ_BASE   = 16'h1400,
    parameter int          PRESCALE   = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        we,
    input  logic [7:0]  dIn,
    output logic [7:0]  dOut,
    output logic        hit,
    input  logic [1:0]  irq_ext,
    output logic        irq,
    output logic        tiq
);
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [15:0] A_CTL = TIMER_BASE + 16'd1;
    localparam logic [15:0] A_MSK = IRQ_BASE + 16'd2;
    localparam logic [15:0] A_ACK = IRQ_BASE + 16'd3;
    logic [6:0]    reload, counter;
    logic [PW-1:0] prescaler;
    logic [2:0]    mask;
    logic          enable, tiq_pend;
    logic          sel_cnt, sel_ctl, sel_msk, sel_ack, rd_hit, unused_d7;
    logic [7:0]    rd_data;
    assign sel_cnt   = addr == TIMER_BASE;
    assign sel_ctl   = addr == A_CTL;
    assign sel_msk   = addr == A_MSK;
    assign sel_ack   = addr == A_ACK;
    assign rd_hit    = !we && (sel_cnt || sel_ctl || sel_msk || sel_ack);
    assign unused_d7 = dIn[7];
    assign tiq       = tiq_pend;
    always_comb begin
        rd_data = !rd_hit                ? 8'h00 :
                  (sel_cnt || sel_ctl)   ? {1'b0, counter} :
                  sel_msk                ? {5'b0, mask} :
                                           {5'b0, tiq_pend, irq_ext};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            reload    <= '0;
            counter   <= '0;
            enable    <= 1'b0;
            prescaler <= PMAX;
            mask      <= '0;
            tiq_pend  <= 1'b0;
            dOut      <= '0;
            hit       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            dOut <= rd_data;
            hit  <= rd_hit;
            irq  <= |({tiq_pend, irq_ext} & ~mask);
            if (we && sel_cnt) reload <= dIn[6:0];
            if (we && sel_msk) mask <= dIn[2:0];
            if (we && sel_ack) tiq_pend <= 1'b0;
            if (we && sel_ctl) enable <= dIn[0];
            // Underflow below is written after the ack so a coincident set wins
            if (we && sel_ctl && dIn[0] && !enable) begin
                counter   <= reload;
                prescaler <= PMAX;
            end else if (enable) begin
                if (prescaler != '0) begin
                    prescaler <= prescaler - 1'b1;
                end else begin
                    prescaler <= PMAX;
                    if (counter != '0) begin
                        counter <= counter - 1'b1;
                    end else begin
                        counter  <= reload;
                        tiq_pend <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_huc6280_timer_irq.sv
// tb_huc6280_timer_irq: directed table plus timer/irq sequences with PRESCALE=4
module tb_huc6280_timer_irq;
    logic        clk = 1'b0;
    logic        reset, we, hit, irq, tiq;
    logic [15:0] addr;
    logic [7:0]  dIn, dOut;
    logic [1:0]  irq_ext;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    huc6280_timer_irq #(.PRESCALE(4)) dut (
        .clk(clk), .reset(reset), .addr(addr), .we(we), .dIn(dIn),
        .dOut(dOut), .hit(hit), .irq_ext(irq_ext), .irq(irq), .tiq(tiq)
    );

    typedef struct {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
        logic [1:0]  x;
        logic [7:0]  dout;
        logic        hit;
        logic        irq;
    } vec_t;
    vec_t v[14];

    task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d);
        addr = a;
        we   = w;
        dIn  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic logic [7:0] cnt_model(input int j);
        return (j < 4) ? 8'd2 : (j < 8) ? 8'd1 : (j < 12) ? 8'd0 : 8'd2;
    endfunction

    initial begin
        v[0]  = '{16'h1402, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0};
        v[1]  = '{16'h0C00, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0};
        v[2]  = '{16'h0C02, 1'b0, 8'h00, 2'b00, 8'h00, 1'b0, 1'b0};
        v[3]  = '{16'h1402, 1'b1, 8'hFF, 2'b00, 8'h00, 1'b0, 1'b0};
        v[4]  = '{16'h1402, 1'b0, 8'h00, 2'b00, 8'h07, 1'b1, 1'b0};
        v[5]  = '{16'h1403, 1'b0, 8'h00, 2'b11, 8'h03, 1'b1, 1'b0};
        v[6]  = '{16'h1402, 1'b1, 8'h04, 2'b11, 8'h00, 1'b0, 1'b0};
        v[7]  = '{16'h1403, 1'b0, 8'h00, 2'b10, 8'h02, 1'b1, 1'b1};
        v[8]  = '{16'h1402, 1'b1, 8'h06, 2'b10, 8'h00, 1'b0, 1'b1};
        v[9]  = '{16'h1402, 1'b0, 8'h00, 2'b10, 8'h06, 1'b1, 1'b0};
        v[10] = '{16'h1401, 1'b0, 8'h00, 2'b01, 8'h00, 1'b0, 1'b1};
        v[11] = '{16'h0C00, 1'b1, 8'h82, 2'b00, 8'h00, 1'b0, 1'b0};
        v[12] = '{16'h0C01, 1'b0, 8'h00, 2'b00, 8'h00, 1'b1, 1'b0};
        v[13] = '{16'h1402, 1'b1, 8'h03, 2'b00, 8'h00, 1'b0, 1'b0};

        reset   = 1'b1;
        irq_ext = 2'b00;
        step(16'h0000, 1'b0, 8'h00);
        step(16'h0000, 1'b0, 8'h00);
        reset = 1'b0;
        chk("reset dout", dOut, 8'h00);
        chk("reset hit", {7'b0, hit}, 8'h00);
        chk("reset irq", {7'b0, irq}, 8'h00);
        chk("reset tiq", {7'b0, tiq}, 8'h00);

        for (int i = 0; i < 14; i++) begin
            irq_ext = v[i].x;
            step(v[i].a, v[i].w, v[i].d);
            chk($sformatf("vec%0d dout", i), dOut, v[i].dout);
            chk($sformatf("vec%0d hit", i), {7'b0, hit}, {7'b0, v[i].hit});
            chk($sformatf("vec%0d irq", i), {7'b0, irq}, {7'b0, v[i].irq});
        end
        irq_ext = 2'b00;

        // enable at edge T0 with reload=2, mask=011 so only the timer can interrupt
        step(16'h0C01, 1'b1, 8'h01);
        for (int k = 1; k <= 12; k++) begin
            step(16'h0C00, 1'b0, 8'h00);
            chk($sformatf("count T0+%0d", k), dOut, cnt_model(k - 1));
            chk($sformatf("tiq T0+%0d", k), {7'b0, tiq}, (k >= 12) ? 8'h01 : 8'h00);
        end
        chk("irq at underflow edge", {7'b0, irq}, 8'h00);
        step(16'h1403, 1'b0, 8'h00);
        chk("status after underflow", dOut, 8'h04);
        chk("irq T0+13", {7'b0, irq}, 8'h01);
        step(16'h1403, 1'b1, 8'hFF);
        chk("tiq after ack", {7'b0, tiq}, 8'h00);
        chk("irq on ack edge", {7'b0, irq}, 8'h01);
        step(16'h0000, 1'b0, 8'h00);
        chk("irq after ack", {7'b0, irq}, 8'h00);
        for (int k = 0; k < 8; k++) step(16'h0000, 1'b0, 8'h00);
        step(16'h1403, 1'b1, 8'hFF);
        chk("ack on underflow edge tiq", {7'b0, tiq}, 8'h01);
        step(16'h0C00, 1'b0, 8'h00);
        chk("reloaded counter", dOut, 8'h02);
        chk("irq after set-wins", {7'b0, irq}, 8'h01);

        for (int k = 0; k < 3; k++) step(16'h0000, 1'b0, 8'h00);
        step(16'h0C01, 1'b1, 8'h00);
        for (int k = 0; k < 20; k++) begin
            step(16'h0C00, 1'b0, 8'h00);
            chk($sformatf("hold %0d", k), dOut, 8'h01);
        end
        step(16'h0C00, 1'b1, 8'h05);
        step(16'h0C01, 1'b1, 8'h01);
        for (int k = 1; k <= 5; k++) begin
            step(16'h0C00, 1'b0, 8'h00);
            chk($sformatf("reenable E+%0d", k), dOut, (k < 5) ? 8'h05 : 8'h04);
        end

        chk("tiq before reset", {7'b0, tiq}, 8'h01);
        reset = 1'b1;
        step(16'h1402, 1'b1, 8'h07);
        reset = 1'b0;
        chk("midrun reset tiq", {7'b0, tiq}, 8'h00);
        chk("midrun reset irq", {7'b0, irq}, 8'h00);
        chk("midrun reset dout", dOut, 8'h00);
        chk("midrun reset hit", {7'b0, hit}, 8'h00);
        step(16'h0C00, 1'b0, 8'h00);
        chk("post reset counter", dOut, 8'h00);
        chk("post reset counter hit", {7'b0, hit}, 8'h01);
        step(16'h1402, 1'b0, 8'h00);
        chk("post reset mask", dOut, 8'h00);
        chk("post reset mask hit", {7'b0, hit}, 8'h01);
        step(16'h0C02, 1'b0, 8'h00);
        chk("0C02 hit", {7'b0, hit}, 8'h00);
        for (int k = 0; k < 8; k++) step(16'h0000, 1'b0, 8'h00);
        step(16'h0C00, 1'b0, 8'h00);
        chk("timer stopped after reset", dOut, 8'h00);
        chk("irq quiet after reset", {7'b0, irq}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
